game_sequencer: RTL

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer_if.sv | 37 +++
 rtl/game_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/game_sequencer_if.sv
// Purpose: bundles the game sequencer's frame/ball/brick inputs and its
//          game-status outputs into one connection.
// Signals:
//   frame_pulse    one-cycle end-of-frame strobe
//   start_btn      synchronised start/launch button level
//   ball_y         current ball y position
//   brick_hit      one-cycle strobe per destroyed brick
//   bricks_cleared high when no bricks remain
//   do_move        ball motion enable (PLAY only)
//   ball_respawn   one-cycle ball reload strobe
//   lives          remaining lives
//   score          bricks destroyed this game (saturating)
//   game_state     encoded sequencer state
// Modports: master drives the inputs and observes the status,
//           slave is the sequencer itself.
interface game_sequencer_if;
  logic       frame_pulse;
  logic       start_btn;
  logic [8:0] ball_y;
  logic       brick_hit;
  logic       bricks_cleared;
  logic       do_move;
  logic       ball_respawn;
  logic [1:0] lives;
  logic [9:0] score;
  logic [2:0] game_state;

  modport master (
    output frame_pulse, start_btn, ball_y, brick_hit, bricks_cleared,
    input  do_move, ball_respawn, lives, score, game_state
  );

  modport slave (
    input  frame_pulse, start_btn, ball_y, brick_hit, bricks_cleared,
    output do_move, ball_respawn, lives, score, game_state
  );
endinterface

// File: rtl/game_sequencer.sv
// Purpose: frame-paced game flow controller for a brick-breaker game:
//          IDLE -> SERVE -> PLAY -> MISS/WIN/GAME_OVER -> IDLE, with lives,
//          a saturating score and a ball respawn strobe.
// Ports:
//   clk    system clock, rising edge
//   nRst   asynchronous active-low reset
//   bus    game_sequencer_if.slave (inputs: frame_pulse, start_btn, ball_y,
//          brick_hit, bricks_cleared; outputs: do_move, ball_respawn, lives,
//          score, game_state)
module game_sequencer #(
  parameter int unsigned LIVES       = 3,
  parameter logic [8:0]  MISS_Y      = 9'd470,
  parameter int unsigned MISS_FRAMES = 60,
  parameter int unsigned END_FRAMES  = 180
) (
  input  logic            clk,
  input  logic            nRst,
  game_sequencer_if.slave bus
);

  localparam int unsigned CNT_MAX   = (MISS_FRAMES > END_FRAMES) ? MISS_FRAMES : END_FRAMES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned SCORE_W   = 10;
  localparam int unsigned LIVES_W   = 2;
  localparam logic [CNT_W-1:0]   MISS_LAST = CNT_W'(MISS_FRAMES - 1);
  localparam logic [CNT_W-1:0]   END_LAST  = CNT_W'(END_FRAMES - 1);
  localparam logic [CNT_W-1:0]   CNT_TOP   = CNT_W'(CNT_MAX);
  localparam logic [SCORE_W-1:0] SCORE_TOP = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_MISS  = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 start_req_q, start_req_d;
  logic                 start_prev_q;
  logic                 respawn_q, respawn_d;
  logic                 do_move_q, do_move_d;
  logic                 start_rise;

  assign start_rise = bus.start_btn & ~start_prev_q;

  // Next-state, counters and strobes.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    cnt_d       = cnt_q;
    respawn_d   = 1'b0;
    // A request is consumed by each frame; a rise on the frame cycle itself
    // is carried into the next frame.
    start_req_d = bus.frame_pulse ? start_rise : (start_req_q | start_rise);

    if (state_q == S_PLAY && bus.brick_hit && score_q != SCORE_TOP) begin
      score_d = score_q + SCORE_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.frame_pulse && start_req_q) begin
          state_d   = S_SERVE;
          lives_d   = LIVES_W'(LIVES);
          score_d   = '0;
          respawn_d = 1'b1;
        end
      end
      S_SERVE: begin
        if (bus.frame_pulse && start_req_q) begin
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // Clearing the field wins over a simultaneous miss.
        if (bus.frame_pulse) begin
          if (bus.bricks_cleared) begin
            state_d = S_WIN;
          end else if (bus.ball_y >= MISS_Y) begin
            state_d = S_MISS;
            if (lives_q != '0) begin
              lives_d = lives_q - LIVES_W'(1);
            end
          end
        end
      end
      S_MISS: begin
        if (bus.frame_pulse && cnt_q == MISS_LAST) begin
          if (lives_q == '0) begin
            state_d = S_OVER;
          end else begin
            state_d   = S_SERVE;
            respawn_d = 1'b1;
          end
        end
      end
      S_OVER, S_WIN: begin
        if (bus.frame_pulse && cnt_q == END_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        // Illegal encoding: recover without waiting for a frame.
        state_d = S_IDLE;
      end
    endcase

    // Frame counter restarts on every state change; saturates while parked.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (bus.frame_pulse && cnt_q != CNT_TOP) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    do_move_d = (state_d == S_PLAY);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= S_IDLE;
      lives_q      <= '0;
      score_q      <= '0;
      cnt_q        <= '0;
      start_req_q  <= 1'b0;
      start_prev_q <= 1'b0;
      respawn_q    <= 1'b0;
      do_move_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      cnt_q        <= cnt_d;
      start_req_q  <= start_req_d;
      start_prev_q <= bus.start_btn;
      respawn_q    <= respawn_d;
      do_move_q    <= do_move_d;
    end
  end

  assign bus.game_state   = state_q;
  assign bus.lives        = lives_q;
  assign bus.score        = score_q;
  assign bus.do_move      = do_move_q;
  assign bus.ball_respawn = respawn_q;

endmodule
